// File: rtl/pnl_pkg.sv
// Shared definitions for the PNL BRAM arbiter slice.
//   PNL_BRAM_ADDR_SIZE_NB   : default PNL BRAM address width
//   PNL_BRAM_DBITS_WIDTH_NB : default PNL BRAM data width
//   arb_state_t             : arbiter FSM states
package pnl_pkg;

  localparam int PNL_BRAM_ADDR_SIZE_NB   = 14;
  localparam int PNL_BRAM_DBITS_WIDTH_NB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pnl_bram_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index where the search starts (wraps modulo NUM_REQ)
//   mask  : requesters that must not be picked (must-release flags)
//   found : at least one eligible requester
//   idx   : first eligible requester at or after ptr
module rr_pick
  import pnl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // One extra bit so ptr+i cannot overflow before the explicit wrap.
  localparam int SW = ID_W + 1;

  logic [NUM_REQ-1:0] elig;
  logic [SW-1:0]      cand;

  assign elig = req & ~mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + SW'(i);
      if (cand >= SW'(NUM_REQ)) begin
        cand = cand - SW'(NUM_REQ);
      end
      if (!found && elig[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pnl_bram_arbiter.sv
// Round-robin lock arbiter for the single-port PNL BRAM.
//   clk, reset        : clock, synchronous active-high reset
//   req               : per-requester ownership request (held for the operation)
//   req_addr/din/we   : packed per-requester BRAM address, write data, write enable
//   grant, grant_id   : one-hot registered grant and owner index
//   busy              : port currently owned
//   PNL_BRAM_addr/din/we : muxed BRAM interface (zero when unowned)
//   timeout_err       : one-cycle pulse when the hold watchdog revokes a grant
//   timeout_id        : requester revoked at the most recent timeout
module pnl_bram_arbiter
  import pnl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = PNL_BRAM_ADDR_SIZE_NB,
  parameter int DATA_W   = PNL_BRAM_DBITS_WIDTH_NB,
  parameter int MAX_HOLD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_din,
  input  logic [NUM_REQ-1:0]          req_we,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [ADDR_W-1:0]           PNL_BRAM_addr,
  output logic [DATA_W-1:0]           PNL_BRAM_din,
  output logic                        PNL_BRAM_we,
  output logic                        timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]  timeout_id
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  // Explicit compare-and-reset so non-power-of-2 NUM_REQ wraps correctly.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  arb_state_t          state, state_n;
  logic [ID_W-1:0]     ptr, ptr_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [ID_W-1:0]     grant_id_n;
  logic                busy_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic                timeout_err_n;
  logic [ID_W-1:0]     timeout_id_n;
  logic [NUM_REQ-1:0]  must_rel, must_rel_n;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (must_rel),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    grant_n       = grant;
    grant_id_n    = grant_id;
    busy_n        = busy;
    hold_cnt_n    = hold_cnt;
    timeout_err_n = 1'b0;
    timeout_id_n  = timeout_id;
    // A must-release flag clears once its requester has been seen low.
    must_rel_n    = must_rel & req;

    unique case (state)
      IDLE, TURN: begin
        if (pick_found) begin
          state_n    = OWNED;
          grant_n    = NUM_REQ'(1) << pick_idx;
          grant_id_n = pick_idx;
          busy_n     = 1'b1;
          hold_cnt_n = '0;
        end else begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
        end
      end
      OWNED: begin
        if (!req[grant_id]) begin
          state_n = TURN;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = next_id(grant_id);
        end else if ((MAX_HOLD > 0) && (hold_cnt == HOLD_LIM)) begin
          // Revoke a hung owner; it must drop req before it can win again.
          state_n              = TURN;
          grant_n              = '0;
          busy_n               = 1'b0;
          ptr_n                = next_id(grant_id);
          timeout_err_n        = 1'b1;
          timeout_id_n         = grant_id;
          must_rel_n[grant_id] = 1'b1;
        end else if ((MAX_HOLD > 0) && (hold_cnt != '1)) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
      must_rel    <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      busy        <= busy_n;
      hold_cnt    <= hold_cnt_n;
      timeout_err <= timeout_err_n;
      timeout_id  <= timeout_id_n;
      must_rel    <= must_rel_n;
    end
  end

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] din_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign din_arr[g]  = req_din[g*DATA_W +: DATA_W];
  end

  // Outputs are zero whenever nobody owns the port (IDLE and the TURN gap).
  // Gating we with the owner's live req drops a write issued on release.
  assign PNL_BRAM_addr = busy ? addr_arr[grant_id] : '0;
  assign PNL_BRAM_din  = busy ? din_arr[grant_id]  : '0;
  assign PNL_BRAM_we   = busy & req[grant_id] & req_we[grant_id] & ~reset;

endmodule

// File: tb/tb_pnl_bram_arbiter.sv
// Directed bench for pnl_bram_arbiter: a 4-requester instance with an
// 8-cycle hold watchdog and a 3-requester instance without watchdog.
module tb_pnl_bram_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [3:0]      req, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] din;
  logic [3:0]      grant;
  logic [1:0]      gid, tid;
  logic            busy, bwe, terr;
  logic [AW-1:0]   baddr;
  logic [DW-1:0]   bdin;

  logic [2:0]      req3, we3;
  logic [3*AW-1:0] addr3;
  logic [3*DW-1:0] din3;
  logic [2:0]      grant3;
  logic [1:0]      gid3, tid3;
  logic            busy3, bwe3, terr3;
  logic [AW-1:0]   baddr3;
  logic [DW-1:0]   bdin3;

  pnl_bram_arbiter #(
    .NUM_REQ (4), .ADDR_W (AW), .DATA_W (DW), .MAX_HOLD (8)
  ) u_dut (
    .clk (clk), .reset (reset), .req (req), .req_addr (addr), .req_din (din),
    .req_we (we), .grant (grant), .grant_id (gid), .busy (busy),
    .PNL_BRAM_addr (baddr), .PNL_BRAM_din (bdin), .PNL_BRAM_we (bwe),
    .timeout_err (terr), .timeout_id (tid)
  );

  pnl_bram_arbiter #(
    .NUM_REQ (3), .ADDR_W (AW), .DATA_W (DW), .MAX_HOLD (0)
  ) u_dut3 (
    .clk (clk), .reset (reset), .req (req3), .req_addr (addr3), .req_din (din3),
    .req_we (we3), .grant (grant3), .grant_id (gid3), .busy (busy3),
    .PNL_BRAM_addr (baddr3), .PNL_BRAM_din (bdin3), .PNL_BRAM_we (bwe3),
    .timeout_err (terr3), .timeout_id (tid3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; din = '0;
    req3 = '0; we3 = '0; addr3 = '0; din3 = '0;
    cyc(3);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_terr", terr, 0);
    chk("rst_tid", tid, 0);
    chk("rst_bram", {baddr, bdin, bwe}, 0);
    reset = 1'b0;
    cyc(1);

    // Single requester
    req[1] = 1'b1; we[1] = 1'b1;
    addr[AW +: AW] = 14'h0040; din[DW +: DW] = 16'h1234;
    cyc(1);
    chk("single_grant", grant, 4'b0010);
    chk("single_gid", gid, 1);
    chk("single_busy", busy, 1);
    chk("single_addr", baddr, 14'h0040);
    chk("single_din", bdin, 16'h1234);
    chk("single_we", bwe, 1);
    cyc(3);
    chk("single_hold", grant, 4'b0010);
    cyc(1);
    req[1] = 1'b0;
    #1;
    chk("single_drop_we", bwe, 0);
    chk("single_drop_busy", busy, 1);
    cyc(1);
    chk("single_rel", {busy, grant}, 0);
    chk("single_rel_bram", {baddr, bdin}, 0);
    we[1] = 1'b0;
    cyc(1);

    // Round-robin from pointer 0
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    req = 4'hf;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("rr_grant", grant, 32'd1 << order[k]);
      chk("rr_gid", gid, order[k]);
      cyc(2);
      req[order[k]] = 1'b0;
      cyc(1);
      chk("rr_turn", {busy, grant}, 0);
      if (k < 4) req[order[k]] = 1'b1;
      else       req = '0;
    end
    cyc(1);

    // Write suppressed on release
    req[2] = 1'b1; we[2] = 1'b1;
    cyc(1);
    chk("ws_grant", grant, 4'b0100);
    chk("ws_we_on", bwe, 1);
    cyc(1);
    req[2] = 1'b0;
    #1;
    chk("ws_drop_we", bwe, 0);
    cyc(1);
    chk("ws_turn", {busy, bwe}, 0);
    we[2] = 1'b0;
    cyc(1);

    // Watchdog on requester 0
    req[0] = 1'b1;
    cyc(1);
    chk("wd_grant", grant, 4'b0001);
    req[3] = 1'b1;
    cyc(6);
    chk("wd_g6", {busy, terr}, 2'b10);
    cyc(1);
    chk("wd_g7", {busy, terr}, 2'b10);
    cyc(1);
    chk("wd_revoke", {busy, grant}, 0);
    chk("wd_terr", terr, 1);
    chk("wd_tid", tid, 0);
    cyc(1);
    chk("wd_pulse", terr, 0);
    chk("wd_next", grant, 4'b1000);
    cyc(1);
    req[3] = 1'b0;
    cyc(1);
    chk("wd_turn", grant, 0);
    cyc(1);
    chk("wd_blocked", {busy, grant}, 0);
    req[0] = 1'b0;
    cyc(1);
    req[0] = 1'b1;
    cyc(1);
    chk("wd_regrant", grant, 4'b0001);
    req[0] = 1'b0;
    cyc(2);

    // Watchdog on requester 1
    req[1] = 1'b1;
    cyc(1);
    chk("wd1_grant", grant, 4'b0010);
    cyc(8);
    chk("wd1_revoke", {busy, terr}, 2'b01);
    chk("wd1_tid", tid, 1);
    req[1] = 1'b0;
    cyc(1);
    chk("wd1_tid_hold", {terr, tid}, 3'b001);
    cyc(1);

    // Reset mid-grant
    req[1] = 1'b1; we[1] = 1'b1;
    cyc(1);
    chk("rm_grant", grant, 4'b0010);
    chk("rm_we_pre", bwe, 1);
    reset = 1'b1;
    #1;
    chk("rm_we_rst", bwe, 0);
    cyc(1);
    reset = 1'b0;
    req[2] = 1'b1;
    chk("rm_cleared", {busy, grant}, 0);
    cyc(1);
    chk("rm_first", grant, 4'b0010);
    req = '0; we = '0;
    cyc(2);

    // NUM_REQ=3 pointer wrap, no watchdog
    req3[2] = 1'b1;
    cyc(1);
    chk("n3_grant2", grant3, 3'b100);
    req3[1:0] = 2'b11;
    cyc(10);
    chk("n3_longhold", {busy3, terr3}, 2'b10);
    req3[2] = 1'b0;
    cyc(1);
    chk("n3_turn", grant3, 0);
    cyc(1);
    chk("n3_wrap", grant3, 3'b001);
    chk("n3_gid", gid3, 0);
    req3 = '0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
